// File: rtl/pixel_binarizer.sv
// ---------------------------------------------------------------------------
// PixelBinarizer
//
// Thresholds an 8-bit grayscale pixel stream into a 1-bit frame memory.
// Pixels are written in y-fastest order: y runs 0..IMG_Y-1, then wraps while
// x advances through 0..IMG_X-1. A frame starts with a pixel tagged sof. The
// last write pulses frameDone, which hands the frame to a downstream median
// stage. The block then waits for that stage to finish (medianBusy high, then
// low again) before it accepts the next frame.
//
// Optional feature: defining PIXEL_BINARIZER_ONES_COUNT_EN adds a 16-bit
// onesCount output. It holds the number of 1 bits written in the current
// frame.
//
// Ports
//   clk                  : clock
//   reset                : asynchronous active-low reset
//   sof                  : start-of-frame tag, sampled with pixelValid
//   pixelValid           : pixelIn is valid
//   pixelIn[7:0]         : grayscale pixel
//   pixelThreshold[7:0]  : binarization level (bit = pixelIn >= threshold)
//   medianBusy           : downstream median stage owns the frame memory
//   pixelReady           : a pixel is accepted this cycle if pixelValid
//   xAddressOut[7:0]     : write x address
//   yAddressOut[7:0]     : write y address
//   binaryDataOut        : bit to write
//   binaryMemWriteEnable : write strobe, one cycle after acceptance
//   frameDone            : pulse coincident with the last pixel's write
//   frameError           : pulse on a malformed frame
//   onesCount[15:0]      : count of 1 bits in the frame (optional)
// ---------------------------------------------------------------------------
module pixel_binarizer #(
    parameter int IMG_X = 240,
    parameter int IMG_Y = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sof,
    input  logic       pixelValid,
    input  logic [7:0] pixelIn,
    input  logic [7:0] pixelThreshold,
    input  logic       medianBusy,
    output logic       pixelReady,
    output logic [7:0] xAddressOut,
    output logic [7:0] yAddressOut,
    output logic       binaryDataOut,
    output logic       binaryMemWriteEnable,
    output logic       frameDone,
    output logic       frameError
`ifdef PIXEL_BINARIZER_ONES_COUNT_EN
    ,
    output logic [15:0] onesCount
`endif
);

    localparam logic [7:0] X_LAST = 8'(IMG_X - 1);
    localparam logic [7:0] Y_LAST = 8'(IMG_Y - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        FILL,
        DONE
    } stateT;

    stateT      r_state;
    stateT      w_nextState;

    logic [7:0] r_xCount;
    logic [7:0] r_yCount;
    logic [1:0] r_doneCycles;
    logic       r_sawBusy;

    logic [7:0] r_xOut;
    logic [7:0] r_yOut;
    logic       r_bit;
    logic       r_writeEnable;
    logic       r_frameDone;
    logic       r_frameError;

    logic       w_pixelReady;
    logic       w_write;
    logic       w_restart;
    logic       w_error;
    logic       w_isLast;
    logic       w_bit;
    logic [7:0] w_writeX;
    logic [7:0] w_writeY;
    logic [7:0] w_nextX;
    logic [7:0] w_nextY;

    assign w_bit = (pixelIn >= pixelThreshold);

    // The write address is (0,0) whenever an sof pixel is taken. Otherwise it
    // is the address the counters hold for the next pixel. The last-pixel
    // test looks at this write address, not at the counters, so a frame that
    // is only one pixel still ends on the sof write.
    always_comb begin
        w_nextState  = r_state;
        w_pixelReady = 1'b0;
        w_write      = 1'b0;
        w_restart    = 1'b0;
        w_error      = 1'b0;
        w_writeX     = r_xCount;
        w_writeY     = r_yCount;

        case (r_state)
            IDLE: begin
                if (!medianBusy) begin
                    w_nextState = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                w_pixelReady = 1'b1;
                if (pixelValid && sof) begin
                    w_write     = 1'b1;
                    w_restart   = 1'b1;
                    w_writeX    = 8'd0;
                    w_writeY    = 8'd0;
                    w_nextState = FILL;
                end
            end
            FILL: begin
                w_pixelReady = 1'b1;
                if (medianBusy) begin
                    w_error     = 1'b1;
                    w_nextState = IDLE;
                end else if (pixelValid) begin
                    w_write = 1'b1;
                    if (sof) begin
                        w_restart = 1'b1;
                        w_error   = 1'b1;
                        w_writeX  = 8'd0;
                        w_writeY  = 8'd0;
                    end
                end
            end
            DONE: begin
                if (!medianBusy && (r_sawBusy || r_doneCycles == 2'd3)) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        w_isLast = w_write && (w_writeX == X_LAST) && (w_writeY == Y_LAST);
        if (w_isLast) begin
            w_nextState = DONE;
        end
    end

    // Step the address after the write. y runs fastest and wraps into x.
    // After the last pixel the address wraps to (0,0), so it stays in range.
    always_comb begin
        w_nextX = w_writeX;
        w_nextY = w_writeY + 8'd1;
        if (w_writeY == Y_LAST) begin
            w_nextY = 8'd0;
            w_nextX = (w_writeX == X_LAST) ? 8'd0 : w_writeX + 8'd1;
        end
    end

    // State register. The DONE bookkeeping is cleared outside DONE, so each
    // frame starts its wait for the median handshake from scratch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_doneCycles <= 2'd0;
            r_sawBusy    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == DONE) begin
                if (r_doneCycles != 2'd3) begin
                    r_doneCycles <= r_doneCycles + 2'd1;
                end
                r_sawBusy <= r_sawBusy | medianBusy;
            end else begin
                r_doneCycles <= 2'd0;
                r_sawBusy    <= 1'b0;
            end
        end
    end

    // Address counters only move on a write, so they hold the next write
    // address at all times.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_xCount <= 8'd0;
            r_yCount <= 8'd0;
        end else if (w_write) begin
            r_xCount <= w_nextX;
            r_yCount <= w_nextY;
        end
    end

    // Registered write port. Data and address are presented one cycle after
    // the pixel is accepted. The pulses are aligned with that write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_xOut        <= 8'd0;
            r_yOut        <= 8'd0;
            r_bit         <= 1'b0;
            r_writeEnable <= 1'b0;
            r_frameDone   <= 1'b0;
            r_frameError  <= 1'b0;
        end else begin
            r_writeEnable <= w_write;
            r_frameDone   <= w_isLast;
            r_frameError  <= w_error;
            if (w_write) begin
                r_xOut <= w_writeX;
                r_yOut <= w_writeY;
                r_bit  <= w_bit;
            end
        end
    end

`ifdef PIXEL_BINARIZER_ONES_COUNT_EN
    logic [15:0] r_onesCount;

    // The sof write restarts the count with its own bit. The count changes
    // only on writes, so it holds from frameDone until the next sof.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_onesCount <= 16'd0;
        end else if (w_write) begin
            if (w_restart) begin
                r_onesCount <= 16'(w_bit);
            end else begin
                r_onesCount <= r_onesCount + 16'(w_bit);
            end
        end
    end

    assign onesCount = r_onesCount;
`endif

    assign pixelReady           = w_pixelReady;
    assign xAddressOut          = r_xOut;
    assign yAddressOut          = r_yOut;
    assign binaryDataOut        = r_bit;
    assign binaryMemWriteEnable = r_writeEnable;
    assign frameDone            = r_frameDone;
    assign frameError           = r_frameError;

endmodule

// File: doc/pixel_binarizer.md
PIXEL_BINARIZER -- requirements
Module: pixel_binarizer

Interface
REQ-001 The block SHALL have parameter IMG_X, default 240, meaning the number of x addresses per frame (outer index).
REQ-002 The block SHALL have parameter IMG_Y, default 180, meaning the number of y addresses per column (inner index).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: port clk, input, 1, clock; port reset, input, 1, asynchronous active-low reset.
REQ-004 Remaining ports SHALL be as follows:
- sof input 1: start-of-frame strobe, sampled with pixelValid.
- pixelValid input 1: pixelIn is valid.
- pixelIn input 8: grayscale pixel.
- pixelThreshold input 8: binarization level.
- medianBusy input 1: the downstream median stage is processing the frame memory.
- pixelReady output 1: the block accepts a pixel this cycle.
- xAddressOut output 8: binary memory x address.
- yAddressOut output 8: binary memory y address.
- binaryDataOut output 1: bit to write.
- binaryMemWriteEnable output 1: write strobe to the binary frame memory.
- frameDone output 1: one-cycle pulse that starts the median stage.
- frameError output 1: one-cycle pulse on a malformed frame.

Function
REQ-005 A pixel SHALL be accepted only in a cycle where pixelValid=1 and pixelReady=1.
REQ-006 The binary value SHALL be 1 when pixelIn >= pixelThreshold (unsigned 8-bit compare), else 0.
REQ-007 For an accepted pixel, binaryDataOut, binaryMemWriteEnable=1 and the pixel's x/y addresses SHALL be registered and presented on the following cycle (latency 1).
REQ-008 binaryMemWriteEnable SHALL be 0 in any cycle not following an accepted pixel.
REQ-009 Address order SHALL be y-fastest: y counts 0..IMG_Y-1 and then wraps to 0 while x increments; x counts 0..IMG_X-1.
REQ-010 The state machine SHALL have the states IDLE, WAIT_SOF, FILL and DONE.
REQ-011 IDLE SHALL go to WAIT_SOF when medianBusy=0, with pixelReady=0 in IDLE.
REQ-012 In WAIT_SOF, pixelReady SHALL be 1, and pixels accepted with sof=0 SHALL be discarded (no write).
REQ-013 A pixel accepted in WAIT_SOF with sof=1 SHALL be written at (0,0) and SHALL move the block to FILL.
REQ-014 In FILL, pixelReady SHALL be 1, and each accepted pixel SHALL write the next address.
REQ-015 The pixel written at (IMG_X-1, IMG_Y-1) SHALL move the block to DONE.
REQ-016 frameDone SHALL pulse for one cycle, coincident with the write of the last pixel.
REQ-017 In DONE, pixelReady SHALL be 0; the block SHALL return to IDLE once medianBusy=1 has been seen and medianBusy has then returned to 0.
REQ-018 If medianBusy is still 0 after 4 cycles in DONE, the block SHALL return to IDLE.
REQ-019 If sof=1 is accepted in FILL, the block SHALL pulse frameError, restart the counters, and write that pixel at (0,0).
REQ-020 If medianBusy rises during FILL, the block SHALL pulse frameError and go to IDLE without completing the frame.
REQ-021 Counter widths SHALL be 8 bits, and no address outside 0..IMG_X-1 / 0..IMG_Y-1 SHALL ever be driven.

Reset
REQ-022 On reset=0 (asynchronous), the block SHALL enter IDLE and clear both counters.
REQ-023 On reset, every output SHALL be 0: pixelReady, xAddressOut, yAddressOut, binaryDataOut, binaryMemWriteEnable, frameDone, frameError (and onesCount when enabled).
REQ-024 Reset asserted mid-frame SHALL abandon the frame; no frameDone SHALL be produced and no write SHALL be issued after reset.
REQ-025 After reset deasserts, the first write SHALL occur only after a new sof.

Configuration
REQ-026 With macro PIXEL_BINARIZER_ONES_COUNT_EN defined, a 16-bit output onesCount SHALL exist.
REQ-027 When enabled, onesCount SHALL be cleared on the sof write, incremented on each write with binaryDataOut=1, and held stable from frameDone until the next sof.
REQ-028 When enabled, onesCount SHALL reach a maximum of 43200 at default parameters, with no overflow.
REQ-029 Without PIXEL_BINARIZER_ONES_COUNT_EN, the onesCount port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover a full frame: threshold 128, 43200 pixels with pixelIn = 200 then 50 alternating, valid every cycle -> 43200 writes, y-fastest order, bits 1,0,1,...; frameDone once at the write of (239,179).
REQ-031 The bench SHALL cover the threshold boundary: pixelIn = 128 and 127 with threshold 128 -> bits 1 and 0, each written one cycle after acceptance.
REQ-032 The bench SHALL cover pixels before sof: 5 pixels with sof=0 in WAIT_SOF -> no writes; the next sof pixel is written at (0,0).
REQ-033 The bench SHALL cover sof mid-frame: sof at pixel 1000 -> frameError pulse, and that pixel is written at (0,0).
REQ-034 The bench SHALL cover the medianBusy handshake: medianBusy held 1 after frameDone -> pixelReady stays 0; medianBusy falls -> IDLE then WAIT_SOF, with pixelReady=1.
REQ-035 The bench SHALL cover reset mid-frame: reset low at pixel 5000 -> all outputs 0 immediately; a new frame completes normally. With the macro defined, an all-255 frame at threshold 0 -> onesCount = 43200.
